// File: rtl/seven_seg_scroller.sv
// seven_seg_scroller: stores a segment-pattern message and scrolls it across a multiplexed 4-digit display
module seven_seg_scroller #(
    parameter int REFRESH_DIV = 25000,
    parameter int SCROLL_DIV  = 12500000,
    parameter int MSG_LEN     = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       pause,
    input  logic       restart,
    output logic [7:0] abcdefgh,
    output logic [3:0] digit
);
    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int OW = $clog2(MSG_LEN + 4);
    localparam int PW = OW + 1;
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(SCROLL_DIV);

    typedef enum logic {LOAD, SCROLL} state_t;
    state_t state, state_next;
    logic [CW-1:0] count, len;
    logic [OW-1:0] offset;
    logic [1:0] scan;
    logic [RW-1:0] ref_cnt;
    logic [SW-1:0] scr_cnt;
    logic [7:0] mem [MSG_LEN];
    logic accept, done, ref_tc, scr_step, show;
    logic [PW-1:0] period, sum, pos;
    logic [7:0] seg_next;
    logic [3:0] digit_next;

    assign wr_ready = state == LOAD && count < CW'(MSG_LEN);
    assign accept   = wr_valid && wr_ready && !restart;
    assign done     = accept && (wr_last || count == CW'(MSG_LEN - 1));
    assign ref_tc   = ref_cnt == RW'(REFRESH_DIV - 1);
    assign scr_step = !pause && scr_cnt == SW'(SCROLL_DIV - 1);
    assign period   = PW'(len) + PW'(4);
    // offset < period and scan <= 3, so one conditional subtract wraps the sum
    assign sum      = PW'(offset) + PW'(scan);
    assign pos      = sum >= period ? sum - period : sum;
    assign show     = state == SCROLL && !restart;

    always_ff @(posedge clk) begin
        state <= !reset_n ? LOAD : state_next;
    end

    always_comb begin
        state_next = state == LOAD ? (done ? SCROLL : LOAD) : (restart ? LOAD : SCROLL);
    end

    always_comb begin
        seg_next = 8'hFF;
        for (int i = 0; i < MSG_LEN; i++)
            if (show && pos == PW'(i) && pos < PW'(len)) seg_next = mem[i];
        digit_next = show ? ~(4'b1000 >> scan) : 4'b1111;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MSG_LEN; i++)
            if (accept && count == CW'(i)) mem[i] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count    <= '0;
            len      <= '0;
            offset   <= '0;
            scan     <= '0;
            ref_cnt  <= '0;
            scr_cnt  <= '0;
            abcdefgh <= 8'hFF;
            digit    <= 4'b1111;
        end else begin
            count    <= restart ? '0 : accept ? count + 1'b1 : count;
            len      <= restart ? '0 : done ? count + 1'b1 : len;
            abcdefgh <= seg_next;
            digit    <= digit_next;
            if (state != SCROLL || restart) begin
                offset  <= '0;
                scan    <= '0;
                ref_cnt <= '0;
                scr_cnt <= '0;
            end else begin
                ref_cnt <= ref_tc ? '0 : ref_cnt + 1'b1;
                scan    <= ref_tc ? scan + 1'b1 : scan;
                scr_cnt <= pause ? scr_cnt : scr_step ? '0 : scr_cnt + 1'b1;
                offset  <= !scr_step ? offset : PW'(offset) == period - 1'b1 ? '0 : offset + 1'b1;
            end
        end
    end
endmodule
